// File: rtl/tcm_arbiter.sv
// Two-port arbiter sharing the single-ported TCM controller between instruction fetch (port 0)
// and data (port 1). Requests are issued back-to-back; responses and faults return to the issuer.
module tcm_arbiter #(
  parameter int  TCM_SIZE      = 1024,
  parameter int  BUS_WIDTH     = 32,
  parameter int  BUS_ACC_WIDTH = 2,
  parameter bit  RR            = 1'b1,
  localparam int AW            = $clog2(TCM_SIZE)
) (
  input  logic                     clk,
  input  logic                     rstn,
  // Master 0 (instruction fetch)
  input  logic [AW-1:0]            m0_addr,
  input  logic                     m0_w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] m0_acc,
  input  logic [BUS_WIDTH-1:0]     m0_wdata,
  input  logic                     m0_req,
  output logic                     m0_resp,
  output logic [BUS_WIDTH-1:0]     m0_rdata,
  output logic                     m0_fault,
  // Master 1 (data)
  input  logic [AW-1:0]            m1_addr,
  input  logic                     m1_w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] m1_acc,
  input  logic [BUS_WIDTH-1:0]     m1_wdata,
  input  logic                     m1_req,
  output logic                     m1_resp,
  output logic [BUS_WIDTH-1:0]     m1_rdata,
  output logic                     m1_fault,
  // TCM controller
  output logic [AW-1:0]            t_addr,
  output logic                     t_w_rb,
  output logic [BUS_ACC_WIDTH-1:0] t_acc,
  output logic [BUS_WIDTH-1:0]     t_wdata,
  output logic                     t_req,
  input  logic [BUS_WIDTH-1:0]     t_rdata,
  input  logic                     t_resp,
  input  logic                     t_fault
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;
  logic   w_owner_nxt;
  logic   r_last;
  logic   w_last_nxt;
  logic   w_issue_slot;
  logic   w_grant;
  logic   w_accept;

  // A WAIT cycle that carries the response is also an issue slot, giving bubble-free throughput.
  assign w_issue_slot = (r_state == ST_IDLE) || t_resp;

  // With no request the grant falls to port 0, so the TCM bus idles on port 0's values.
  assign w_grant = (m0_req && m1_req) ? (RR ? ~r_last : 1'b1) : m1_req;

  assign t_req   = w_issue_slot && (m0_req || m1_req);
  assign t_addr  = w_grant ? m1_addr  : m0_addr;
  assign t_w_rb  = w_grant ? m1_w_rb  : m0_w_rb;
  assign t_acc   = w_grant ? m1_acc   : m0_acc;
  assign t_wdata = w_grant ? m1_wdata : m0_wdata;

  assign w_accept = t_req && !t_fault;

  assign m0_resp  = t_resp && (r_state == ST_WAIT) && !r_owner;
  assign m1_resp  = t_resp && (r_state == ST_WAIT) &&  r_owner;
  assign m0_rdata = t_rdata;
  assign m1_rdata = t_rdata;
  assign m0_fault = t_req && t_fault && !w_grant;
  assign m1_fault = t_req && t_fault &&  w_grant;

  always_comb begin
    // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    if (w_accept) begin
      w_state_nxt = ST_WAIT;
      w_owner_nxt = w_grant;
    end else if ((r_state == ST_WAIT) && t_resp) begin
      w_state_nxt = ST_IDLE;
    end
    // A faulted issue still counts as a grant for fairness.
    if (t_req) begin
      w_last_nxt = w_grant;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_tcm_arbiter.sv
// Directed bench for tcm_arbiter: a cycle-by-cycle vector table against a round-robin instance
// with a small TCM model, plus a hand-written fixed-priority sequence on a second instance.
module tb_tcm_arbiter;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;
  localparam logic [9:0]  Z   = 10'h000;
  localparam logic [9:0]  A02 = 10'h002;
  localparam logic [9:0]  A10 = 10'h010;
  localparam logic [9:0]  A14 = 10'h014;
  localparam logic [9:0]  A20 = 10'h020;
  localparam logic [31:0] D0  = 32'h0000_0000;
  localparam logic [31:0] DB  = 32'hDEAD_BEEF;
  localparam logic [31:0] D5  = 32'hA000_0005;
  localparam logic [31:0] DW  = 32'h1234_5678;

  logic        clk;
  logic        rstn;
  logic [9:0]  m0_addr, m1_addr;
  logic        m0_w_rb, m1_w_rb;
  logic [1:0]  m0_acc, m1_acc;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_req, m1_req;

  // Round-robin instance and its TCM model
  logic        a_m0_resp, a_m1_resp, a_m0_fault, a_m1_fault;
  logic [31:0] a_m0_rdata, a_m1_rdata;
  logic [9:0]  a_t_addr;
  logic        a_t_w_rb, a_t_req, a_t_resp, a_t_fault;
  logic [1:0]  a_t_acc;
  logic [31:0] a_t_wdata, a_t_rdata;
  logic [31:0] mem [256];

  // Fixed-priority instance with a fault-free TCM stub
  logic        b_m0_resp, b_m1_resp, b_m0_fault, b_m1_fault;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic [9:0]  b_t_addr;
  logic        b_t_w_rb, b_t_req, b_t_resp;
  logic [1:0]  b_t_acc;
  logic [31:0] b_t_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  tcm_arbiter #(.TCM_SIZE(1024), .BUS_WIDTH(32), .BUS_ACC_WIDTH(2), .RR(1'b1)) u_rr (
    .clk(clk), .rstn(rstn),
    .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc), .m0_wdata(m0_wdata), .m0_req(m0_req),
    .m0_resp(a_m0_resp), .m0_rdata(a_m0_rdata), .m0_fault(a_m0_fault),
    .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc), .m1_wdata(m1_wdata), .m1_req(m1_req),
    .m1_resp(a_m1_resp), .m1_rdata(a_m1_rdata), .m1_fault(a_m1_fault),
    .t_addr(a_t_addr), .t_w_rb(a_t_w_rb), .t_acc(a_t_acc), .t_wdata(a_t_wdata), .t_req(a_t_req),
    .t_rdata(a_t_rdata), .t_resp(a_t_resp), .t_fault(a_t_fault)
  );

  tcm_arbiter #(.TCM_SIZE(1024), .BUS_WIDTH(32), .BUS_ACC_WIDTH(2), .RR(1'b0)) u_fp (
    .clk(clk), .rstn(rstn),
    .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc), .m0_wdata(m0_wdata), .m0_req(m0_req),
    .m0_resp(b_m0_resp), .m0_rdata(b_m0_rdata), .m0_fault(b_m0_fault),
    .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc), .m1_wdata(m1_wdata), .m1_req(m1_req),
    .m1_resp(b_m1_resp), .m1_rdata(b_m1_rdata), .m1_fault(b_m1_fault),
    .t_addr(b_t_addr), .t_w_rb(b_t_w_rb), .t_acc(b_t_acc), .t_wdata(b_t_wdata), .t_req(b_t_req),
    .t_rdata(D0), .t_resp(b_t_resp), .t_fault(L)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TCM model: misaligned accesses fault in the issue cycle; others respond one cycle later.
  assign a_t_fault = a_t_req && (((a_t_acc == 2'd2) && (a_t_addr[1:0] != 2'b00)) ||
                                 ((a_t_acc == 2'd1) && a_t_addr[0]));

  always @(posedge clk) begin
    a_t_resp <= a_t_req && !a_t_fault;
    if (a_t_req && !a_t_fault) begin
      if (a_t_w_rb) mem[a_t_addr[9:2]] <= a_t_wdata;
      else          a_t_rdata <= mem[a_t_addr[9:2]];
    end
    b_t_resp <= b_t_req;
  end

  typedef struct packed {
    logic        rst;
    logic        q0;
    logic        w0;
    logic [9:0]  a0;
    logic        q1;
    logic        w1;
    logic [9:0]  a1;
    logic [31:0] d1;
    logic        treq;
    logic        tw;
    logic [9:0]  taddr;
    logic        r0;
    logic        r1;
    logic        f0;
    logic        f1;
    logic        rc;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic rst, q0, w0, input logic [9:0] a0,
                              input logic q1, w1, input logic [9:0] a1, input logic [31:0] d1,
                              input logic treq, tw, input logic [9:0] taddr,
                              input logic r0, r1, f0, f1, rc, input logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.q0 = q0; v.w0 = w0; v.a0 = a0;
    v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.treq = treq; v.tw = tw; v.taddr = taddr;
    v.r0 = r0; v.r1 = r1; v.f0 = f0; v.f1 = f1; v.rc = rc; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Applies one cycle of master inputs just after the rising edge, then waits for the falling edge.
  task automatic drive(input logic rst, q0, w0, input logic [9:0] a0,
                       input logic q1, w1, input logic [9:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    rstn    = ~rst;
    m0_req  = q0; m0_w_rb = w0; m0_addr = a0;
    m1_req  = q1; m1_w_rb = w1; m1_addr = a1; m1_wdata = d1;
    @(negedge clk);
  endtask

  vec_t vecs [21];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    mem[4] = DB;
    a_t_resp = 1'b0;
    b_t_resp = 1'b0;
    a_t_rdata = D0;
    rstn = 1'b0;
    m0_req = 1'b0; m0_w_rb = 1'b0; m0_addr = Z; m0_acc = 2'd2; m0_wdata = D0;
    m1_req = 1'b0; m1_w_rb = 1'b0; m1_addr = Z; m1_acc = 2'd2; m1_wdata = D0;

    //            rst q0 w0 a0   q1 w1 a1   d1   treq tw taddr r0 r1 f0 f1 rc rd
    vecs[0]  = mk(L, H, L, A10, L, L, Z,   D0, H, L, A10, L, L, L, L, L, D0);  // single read
    vecs[1]  = mk(L, L, L, Z,   L, L, Z,   D0, L, L, Z,   H, L, L, L, H, DB);
    vecs[2]  = mk(L, L, L, Z,   L, L, Z,   D0, L, L, Z,   L, L, L, L, L, D0);
    vecs[3]  = mk(H, L, L, Z,   L, L, Z,   D0, L, L, Z,   L, L, L, L, L, D0);  // reset: last=1
    vecs[4]  = mk(L, H, L, A10, H, L, A14, D0, H, L, A10, L, L, L, L, L, D0);  // RR conflict
    vecs[5]  = mk(L, H, L, A10, H, L, A14, D0, H, L, A14, H, L, L, L, H, DB);
    vecs[6]  = mk(L, H, L, A10, H, L, A14, D0, H, L, A10, L, H, L, L, H, D5);
    vecs[7]  = mk(L, H, L, A10, H, L, A14, D0, H, L, A14, H, L, L, L, H, DB);
    vecs[8]  = mk(L, H, L, A10, L, L, Z,   D0, H, L, A10, L, H, L, L, H, D5);
    vecs[9]  = mk(L, L, L, Z,   L, L, Z,   D0, L, L, Z,   H, L, L, L, H, DB);
    vecs[10] = mk(L, H, L, A10, H, L, A02, D0, H, L, A02, L, L, L, H, L, D0);  // m1 faults
    vecs[11] = mk(L, H, L, A10, L, L, Z,   D0, H, L, A10, L, L, L, L, L, D0);
    vecs[12] = mk(L, L, L, Z,   L, L, Z,   D0, L, L, Z,   H, L, L, L, H, DB);
    vecs[13] = mk(L, L, L, Z,   H, H, A20, DW, H, H, A20, L, L, L, L, L, D0);  // write, then read
    vecs[14] = mk(L, L, L, Z,   H, L, A20, D0, H, L, A20, L, H, L, L, L, D0);
    vecs[15] = mk(L, L, L, Z,   L, L, Z,   D0, L, L, Z,   L, H, L, L, H, DW);
    vecs[16] = mk(L, H, L, A10, L, L, Z,   D0, H, L, A10, L, L, L, L, L, D0);  // reset mid-WAIT
    vecs[17] = mk(H, H, L, A10, H, L, A14, D0, H, L, A14, H, L, L, L, H, DB);
    vecs[18] = mk(L, H, L, A10, H, L, A14, D0, H, L, A10, L, L, L, L, L, D0);
    vecs[19] = mk(L, L, L, Z,   L, L, Z,   D0, L, L, Z,   H, L, L, L, H, DB);
    vecs[20] = mk(L, L, L, Z,   L, L, Z,   D0, L, L, Z,   L, L, L, L, L, D0);

    drive(H, L, L, Z, L, L, Z, D0);
    drive(H, L, L, Z, L, L, Z, D0);
    check("rst_t_req",    {31'd0, a_t_req},    32'd0);
    check("rst_m0_resp",  {31'd0, a_m0_resp},  32'd0);
    check("rst_m1_resp",  {31'd0, a_m1_resp},  32'd0);
    check("rst_m0_fault", {31'd0, a_m0_fault}, 32'd0);
    check("rst_m1_fault", {31'd0, a_m1_fault}, 32'd0);
    check("rst_fp_t_req", {31'd0, b_t_req},    32'd0);

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rst, vecs[i].q0, vecs[i].w0, vecs[i].a0,
            vecs[i].q1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      check($sformatf("v%0d_t_req", i),    {31'd0, a_t_req},    {31'd0, vecs[i].treq});
      check($sformatf("v%0d_t_w_rb", i),   {31'd0, a_t_w_rb},   {31'd0, vecs[i].tw});
      check($sformatf("v%0d_t_addr", i),   {22'd0, a_t_addr},   {22'd0, vecs[i].taddr});
      check($sformatf("v%0d_m0_resp", i),  {31'd0, a_m0_resp},  {31'd0, vecs[i].r0});
      check($sformatf("v%0d_m1_resp", i),  {31'd0, a_m1_resp},  {31'd0, vecs[i].r1});
      check($sformatf("v%0d_m0_fault", i), {31'd0, a_m0_fault}, {31'd0, vecs[i].f0});
      check($sformatf("v%0d_m1_fault", i), {31'd0, a_m1_fault}, {31'd0, vecs[i].f1});
      if (vecs[i].rc) begin
        check($sformatf("v%0d_m0_rdata", i), a_m0_rdata, vecs[i].rd);
        check($sformatf("v%0d_m1_rdata", i), a_m1_rdata, vecs[i].rd);
      end
    end

    // Fixed priority: port 1 takes every slot while it requests; port 0 follows once it drops.
    for (int i = 0; i < 4; i++) begin
      drive(L, H, L, A10, H, L, A14, D0);
      check($sformatf("fp%0d_t_req", i),   {31'd0, b_t_req},   32'd1);
      check($sformatf("fp%0d_t_addr", i),  {22'd0, b_t_addr},  {22'd0, A14});
      check($sformatf("fp%0d_m0_resp", i), {31'd0, b_m0_resp}, 32'd0);
      check($sformatf("fp%0d_m1_resp", i), {31'd0, b_m1_resp}, (i > 0) ? 32'd1 : 32'd0);
    end
    drive(L, H, L, A10, L, L, Z, D0);
    check("fp_drop_t_addr",  {22'd0, b_t_addr},  {22'd0, A10});
    check("fp_drop_m1_resp", {31'd0, b_m1_resp}, 32'd1);
    check("fp_drop_m0_resp", {31'd0, b_m0_resp}, 32'd0);
    drive(L, L, L, Z, L, L, Z, D0);
    check("fp_end_m0_resp",  {31'd0, b_m0_resp}, 32'd1);
    check("fp_end_t_req",    {31'd0, b_t_req},   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tcm_arbiter.md
# tcm_arbiter

Two-port arbiter that shares the single-ported TCM controller between the instruction-fetch master (port 0) and the data master (port 1). It sits between the two core-side bus masters and the TCM controller. It forwards one request at a time, and issues back-to-back requests with no bubble. It routes the one-cycle-later response and the same-cycle fault back to the issuing master. Tie-breaking is round-robin, or fixed priority to port 1 when configured.

## Interface
- AW, `$clog2(TCM_SIZE)`: TCM byte-address width.
- RR, 1: 1 = round-robin on conflict; 0 = port 1 always wins on conflict.
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- mN_addr (N = 0, 1)  in  AW  byte address from master N
- mN_w_rb  in  1  1 = write, 0 = read
- mN_acc  in  BUS_ACC_WIDTH  access size (1B/2B/4B encoding)
- mN_wdata  in  BUS_WIDTH  write data
- mN_req  in  1  request; held until the master sees mN_resp or mN_fault
- mN_resp  out  1  access completed
- mN_rdata  out  BUS_WIDTH  read data; valid only while mN_resp = 1
- mN_fault  out  1  request rejected by the TCM (same cycle as issue)
- t_addr, t_w_rb, t_acc, t_wdata  out  to TCM controller
- t_req  out  1  request to TCM
- t_rdata  in  BUS_WIDTH  TCM read data
- t_resp  in  1  TCM response (registered, one cycle after an accepted t_req)
- t_fault  in  1  TCM fault (combinational with t_req)

## Operation
- State register: IDLE, or WAIT with owner ∈ {0, 1}.
- Also holds a last-grant pointer `last` (1 bit).
- **Issue slot** = state IDLE, or state WAIT with t_resp = 1 (pipelined back-to-back issue).
- **Request sampling:** in an issue slot, the masters' mN_req are sampled. If the owner's own mN_req is high in the same cycle its mN_resp is high, that is a new request.
- **Grant selection** (combinational):
  - Only one requesting: that port is granted.
  - Both requesting, RR=1: grant ~last.
  - Both requesting, RR=0: grant port 1.
- **Forwarding:** t_req = issue slot & (m0_req | m1_req). t_addr, t_w_rb, t_acc and t_wdata are muxed from the granted port; they hold the port 0 values when no grant is made.
- **Accepted issue** (t_req & ~t_fault): next state WAIT with owner = grant; last <= grant.
- **Faulted issue** (t_req & t_fault): mgrant_fault = 1 in the same cycle; last <= grant.
  - Next state: IDLE if no accepted issue follows.
  - Never WAIT on a faulted issue, since the TCM produces no t_resp for it.
- **WAIT, t_resp = 1, no new issue:** next state IDLE.
- **WAIT, t_resp = 0:** stay in WAIT. This is a protocol error; the TCM always responds within one cycle. The state still holds.
- **Response routing:**
  - mN_resp = t_resp & (state == WAIT) & (owner == N).
  - mN_rdata = t_rdata, broadcast to both ports.
- **Fault routing:** mN_fault = t_req & t_fault & (grant == N). The non-granted port never sees a fault.
- **Starvation:** with RR=1, a port that is continuously requesting is granted within 2 issue slots.
- **Reset mid-operation:** state -> IDLE and last -> 1, so port 0 wins the first conflict. Any in-flight response is dropped; masters must also be reset.

## Timing
- Reset values:
  - mN_resp = 0.
  - mN_fault = 0 and t_req = 0 when no master is requesting.
  - mN_rdata follows t_rdata (not reset).
- Latency: mN_req rising in IDLE -> t_req the same cycle -> mN_resp the next cycle (1 cycle, same as the TCM alone).
- Throughput: one access per cycle, including alternating ports under contention.
- Loser latency: a port that loses arbitration waits at least one extra cycle per lost slot, while holding its request.
- No combinational path from mN_req to mN_resp.
- Combinational path mN_req -> t_req -> t_fault -> mN_fault is permitted; the TCM fault decode is shallow.

## Test plan
- **Single read:** m0 reads addr 0x10 (4B), with TCM word 0x10 = 0xDEADBEEF -> t_req in cycle 0; m0_resp = 1 and m0_rdata = 0xDEADBEEF in cycle 1; m1_resp stays 0.
- **Conflict RR:** both request in cycle 0 after reset.
  - Cycle 0: m0 issued. Cycle 1: m0_resp, and m1 issued.
  - Cycle 2: m1_resp. Both held continuously -> grants alternate 0, 1, 0, 1 with no idle cycle.
- **Fixed priority:** RR=0, both request every cycle -> m1 granted every slot and m0 never, until m1 drops req; then m0 is granted the next slot.
- **Fault:** m1 issues 4B access at addr 0x2 -> m1_fault = 1 in the same cycle and m1_resp never asserts.
  - State stays IDLE.
  - A pending m0 request is issued the following cycle.
- **Back-to-back write then read:** m1 writes 0x12345678 to 0x20 (4B), then holds req for a read of 0x20 -> second issue in the cycle of the first resp; next cycle m1_rdata = 0x12345678.
- **Reset mid-WAIT:** rstn low during WAIT -> next cycle m0_resp = m1_resp = 0 and state IDLE; the first conflict after reset grants m0.
